nand_page_xfer: RTL

// - Page data mover between the controller port of the page buffer and the x16 NAND flash data bus.
// - PROGRAM (dir=0): reads PAGE_WORDS words from the buffer and strobes each onto the NAND I/O with nand_we_n.
// - READ (dir=1): strobes PAGE_WORDS words off the NAND with nand_re_n and writes each into the buffer.
// - Command/address cycles are the upstream controller FSM's job; this block handles the data phase only.

---
 rtl/nand_page_xfer_if.sv | 35 +++
 rtl/nand_page_xfer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nand_page_xfer_if.sv
// Bus bundle for nand_page_xfer: start/status handshake, page-buffer
// controller port and x16 NAND data-phase pins.
// master = the transfer engine, slave = the surrounding controller/pads.
interface nand_page_xfer_if #(
  parameter int DataWidth = 16
);
  logic                 start;
  logic                 dir;
  logic                 busy;
  logic                 done;
  logic [15:0]          xfer_crc;
  logic                 cntrl_sel;
  logic                 cntrl_re;
  logic                 cntrl_we;
  logic [DataWidth-1:0] cntrl_in;
  logic [DataWidth-1:0] cntrl_out;
  logic [DataWidth-1:0] nand_io_out;
  logic                 nand_io_oe;
  logic [DataWidth-1:0] nand_io_in;
  logic                 nand_we_n;
  logic                 nand_re_n;
  logic                 nand_rb_n;

  modport master (
    input  start, dir, cntrl_out, nand_io_in, nand_rb_n,
    output busy, done, xfer_crc, cntrl_sel, cntrl_re, cntrl_we, cntrl_in,
           nand_io_out, nand_io_oe, nand_we_n, nand_re_n
  );

  modport slave (
    output start, dir, cntrl_out, nand_io_in, nand_rb_n,
    input  busy, done, xfer_crc, cntrl_sel, cntrl_re, cntrl_we, cntrl_in,
           nand_io_out, nand_io_oe, nand_we_n, nand_re_n
  );
endinterface

// File: rtl/nand_page_xfer.sv
// nand_page_xfer: data-phase mover between the page buffer controller port
// and the x16 NAND bus. dir=0 programs (buffer -> NAND via nand_we_n),
// dir=1 reads (NAND -> buffer via nand_re_n). PAGE_WORDS words per transfer.
// Optional feature macro: XFER_CRC_EN adds a CRC-16-CCITT over the moved
// words, presented on xfer_crc while done is high; otherwise xfer_crc = 0.
module nand_page_xfer #(
  parameter int DataWidth  = 16,
  parameter int PAGE_WORDS = 2048,
  parameter int T_LOW      = 2,
  parameter int T_HIGH     = 1
) (
  input  logic             clk,
  input  logic             rst,
  nand_page_xfer_if.master bus
);

  localparam int CW   = $clog2(PAGE_WORDS) + 1;
  localparam int TMAX = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] LAST_WORD = CW'(PAGE_WORDS - 1);
  localparam logic [TW-1:0] LO_LAST   = TW'(T_LOW - 1);
  localparam logic [TW-1:0] HI_LAST   = TW'(T_HIGH - 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_RB, P_FETCH, P_WAIT, P_WLOW, P_WHIGH, R_LOW, R_HIGH, DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 dir_q;
  logic [CW-1:0]        wcnt_q;
  logic [TW-1:0]        tcnt_q;
  logic [DataWidth-1:0] io_out_q;
  logic [DataWidth-1:0] buf_in_q;

  logic accept;
  logic lo_last;
  logic hi_last;
  logic last_word;
  logic timed_phase;
  logic phase_end;
  logic word_end;

  // Moore outputs decoded from state
  logic busy_c, done_c, sel_c, re_c, we_c, oe_c, we_n_c, re_n_c;

  assign accept      = (state_q == IDLE) && bus.start;
  assign lo_last     = (tcnt_q == LO_LAST);
  assign hi_last     = (tcnt_q == HI_LAST);
  assign last_word   = (wcnt_q == LAST_WORD);
  assign timed_phase = (state_q == P_WLOW) || (state_q == P_WHIGH) ||
                       (state_q == R_LOW)  || (state_q == R_HIGH);
  assign phase_end   = (((state_q == P_WLOW)  || (state_q == R_LOW))  && lo_last) ||
                       (((state_q == P_WHIGH) || (state_q == R_HIGH)) && hi_last);
  assign word_end    = ((state_q == P_WHIGH) || (state_q == R_HIGH)) && hi_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b1;
    done_c  = 1'b0;
    sel_c   = 1'b1;
    re_c    = 1'b0;
    we_c    = 1'b0;
    oe_c    = 1'b0;
    we_n_c  = 1'b1;
    re_n_c  = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        sel_c  = 1'b0;
        if (bus.start) state_d = WAIT_RB;
      end
      WAIT_RB: begin
        if (bus.nand_rb_n) state_d = dir_q ? R_LOW : P_FETCH;
      end
      P_FETCH: begin
        re_c    = 1'b1;
        state_d = P_WAIT;
      end
      P_WAIT: begin
        oe_c    = 1'b1;
        state_d = P_WLOW;
      end
      P_WLOW: begin
        oe_c   = 1'b1;
        we_n_c = 1'b0;
        if (lo_last) state_d = P_WHIGH;
      end
      P_WHIGH: begin
        oe_c = 1'b1;
        if (hi_last) state_d = last_word ? DONE : P_FETCH;
      end
      R_LOW: begin
        re_n_c = 1'b0;
        if (lo_last) state_d = R_HIGH;
      end
      R_HIGH: begin
        // write strobe only on the first high cycle, when tcnt is still 0
        we_c = (tcnt_q == '0);
        if (hi_last) state_d = last_word ? DONE : R_LOW;
      end
      DONE: begin
        busy_c  = 1'b0;
        done_c  = 1'b1;
        sel_c   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_c  = 1'b0;
        sel_c   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Direction latch, word counter and per-phase strobe timer
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q  <= 1'b0;
      wcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (accept) begin
        dir_q  <= bus.dir;
        wcnt_q <= '0;
      end else if (word_end && !last_word) begin
        wcnt_q <= wcnt_q + CW'(1);
      end
      if (timed_phase && !phase_end) tcnt_q <= tcnt_q + TW'(1);
      else                           tcnt_q <= '0;
    end
  end

  // Data capture: buffer word for NAND out, NAND word for buffer in
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out_q <= '0;
      buf_in_q <= '0;
    end else begin
      if (state_q == P_WAIT)            io_out_q <= bus.cntrl_out;
      if ((state_q == R_LOW) && lo_last) buf_in_q <= bus.nand_io_in;
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.cntrl_sel   = sel_c;
  assign bus.cntrl_re    = re_c;
  assign bus.cntrl_we    = we_c;
  assign bus.cntrl_in    = buf_in_q;
  assign bus.nand_io_out = io_out_q;
  assign bus.nand_io_oe  = oe_c;
  assign bus.nand_we_n   = we_n_c;
  assign bus.nand_re_n   = re_n_c;

`ifdef XFER_CRC_EN
  // CRC-16-CCITT, poly 0x1021, MSB first, one full word per call
  function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                             input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [15:0] crc_q;

  // CRC accumulates on the same cycles the data registers capture
  always_ff @(posedge clk) begin
    if (rst)                              crc_q <= 16'h0000;
    else if (accept)                      crc_q <= 16'hFFFF;
    else if (state_q == P_WAIT)           crc_q <= crc16_word(crc_q, 16'(bus.cntrl_out));
    else if ((state_q == R_LOW) && lo_last) crc_q <= crc16_word(crc_q, 16'(bus.nand_io_in));
  end

  assign bus.xfer_crc = (state_q == DONE) ? crc_q : 16'h0000;
`else
  assign bus.xfer_crc = 16'h0000;
`endif

endmodule
